// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit path: the arbiter FSM
// state encoding and the default byte width used by the transmitter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector: the search starts one past the
// last winner and wraps, returning a one-hot grant, its index and any-valid.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_id_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = 0;
    found   = 1'b0;
    // Offsets 1..NUM_REQ visit every requester once, ending on the last winner.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_id_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = ID_W'(cand);
      end
    end
    if (found) grant_o[idx_o] = 1'b1;
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin grant,
// one-cycle start pulse, then wait for the transmitter's ready or a watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  input  logic [NUM_REQ-1:0]           ReqValid,
  input  logic [NUM_REQ*DATA_BITS-1:0] ReqData,
  output logic [NUM_REQ-1:0]           ReqGrant,
  output logic                         TxStart,
  output logic [DATA_BITS-1:0]         TxData,
  input  logic                         TxReady,
  output logic                         Busy,
  output logic [$clog2(NUM_REQ)-1:0]   ActiveId,
  output logic                         Timeout
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   start_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   busy_q;
  logic [ID_W-1:0]        id_q;
  logic                   tmo_q;
  logic [WD_W-1:0]        wdog_q;
  logic [ID_W-1:0]        last_q;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_any;
  logic [DATA_BITS-1:0]   sel_data_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (ReqValid),
    .last_id_i (last_q),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    sel_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) sel_data_d = ReqData[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      grant_q <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      tmo_q   <= 1'b0;
      wdog_q  <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      grant_q <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            data_q  <= sel_data_d;
            id_q    <= arb_idx;
            last_q  <= arb_idx;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_q <= 1'b1;
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Ready is checked first so it beats a simultaneous watchdog expiry.
          if (TxReady) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wdog_q == WD_LAST) begin
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ReqGrant = grant_q;
  assign TxStart  = start_q;
  assign TxData   = data_q;
  assign Busy     = busy_q;
  assign ActiveId = id_q;
  assign Timeout  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DB  = 8;
  localparam int TMO = 16;

  logic            Clock;
  logic            ResetN;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    ReqGrant;
  logic            TxStart;
  logic [DB-1:0]   TxData;
  logic            TxReady;
  logic            Busy;
  logic [1:0]      ActiveId;
  logic            Timeout;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_BITS      (DB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .ReqValid (req_valid),
    .ReqData  (req_data),
    .ReqGrant (ReqGrant),
    .TxStart  (TxStart),
    .TxData   (TxData),
    .TxReady  (TxReady),
    .Busy     (Busy),
    .ActiveId (ActiveId),
    .Timeout  (Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit hold    = 1'b0;
  int glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is granted, started one cycle later, then
  // waits up to TMO cycles after the start for ready.
  int          m_last;
  bit          m_busy;
  int          m_age;
  int          m_id;
  logic [7:0]  m_data;
  bit          e_grant, e_start, e_tmo;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_last = N - 1; m_busy = 0; m_age = 0; m_id = 0; m_data = '0;
      e_grant = 0; e_start = 0; e_tmo = 0;
    end else begin
      e_grant = 0; e_start = 0; e_tmo = 0;
      if (!m_busy) begin
        if (req_valid != '0) begin
          m_id    = rr_pick(m_last, req_valid);
          m_last  = m_id;
          m_data  = req_data[m_id*DB +: DB];
          m_busy  = 1;
          m_age   = 0;
          e_grant = 1;
        end
      end else if (m_age == 0) begin
        m_age   = 1;
        e_start = 1;
      end else begin
        if (TxReady) m_busy = 0;
        else if (m_age - 1 == TMO - 1) begin
          m_busy = 0;
          e_tmo  = 1;
        end else m_age++;
      end
    end
  end

  always @(negedge Clock) begin
    chk("grant",    32'(ReqGrant), e_grant ? 32'(1 << m_id) : 32'd0);
    chk("txstart",  32'(TxStart),  32'(e_start));
    chk("busy",     32'(Busy),     32'(m_busy));
    chk("timeout",  32'(Timeout),  32'(e_tmo));
    chk("txdata",   32'(TxData),   32'(m_data));
    chk("activeid", 32'(ActiveId), 32'(m_id));
    for (int i = 0; i < N; i++) if (ReqGrant[i]) glog.push_back(i);
  end

  task automatic tick();
    @(negedge Clock);
    #1;
    if (!hold) req_valid = req_valid & ~ReqGrant;
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (TxStart) begin ok = 1; break; end
    end
    chk("wait_start_bound", 32'(ok), 32'd1);
  endtask

  task automatic wait_grant();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ReqGrant != '0) begin ok = 1; break; end
    end
    chk("wait_grant_bound", 32'(ok), 32'd1);
  endtask

  task automatic pulse_ready();
    TxReady = 1'b1;
    tick();
    TxReady = 1'b0;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    repeat (2) tick();
    ResetN = 1'b1;
    tick();
    glog.delete();
  endtask

  task automatic chk_log(input string name, input int a0, input int a1, input int a2,
                         input int a3, input int a4, input int len);
    int exp[5];
    exp = '{a0, a1, a2, a3, a4};
    chk({name, "_len"}, 32'(glog.size()), 32'(len));
    for (int i = 0; i < len && i < glog.size(); i++) chk({name, "_id"}, 32'(glog[i]), 32'(exp[i]));
  endtask

  int  n;
  bit  saw;

  initial begin
    ResetN    = 1'b0;
    req_valid = '0;
    req_data  = {8'h44, 8'h33, 8'h22, 8'hAA};
    TxReady   = 1'b0;
    repeat (2) tick();
    chk("reset_busy",  32'(Busy), 32'd0);
    chk("reset_grant", 32'(ReqGrant), 32'd0);
    ResetN = 1'b1;
    tick();

    // Idle: ready while idle is ignored, no grant without requests.
    pulse_ready();
    repeat (3) tick();
    chk("idle_grant", 32'(ReqGrant), 32'd0);
    chk("idle_busy",  32'(Busy), 32'd0);

    // Single request, with a ready pulse during LAUNCH that must be ignored.
    req_valid = 4'b0001;
    wait_grant();
    chk("single_grant", 32'(ReqGrant), 32'h1);
    TxReady = 1'b1;
    tick();
    TxReady = 1'b0;
    chk("single_start", 32'(TxStart), 32'd1);
    chk("single_data",  32'(TxData), 32'hAA);
    repeat (3) tick();
    chk("single_busy_hold", 32'(Busy), 32'd1);
    chk("single_start_once", 32'(TxStart), 32'd0);
    pulse_ready();
    chk("single_busy_clear", 32'(Busy), 32'd0);

    // Fairness with all requesters held high.
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    hold      = 1'b1;
    req_valid = 4'b1111;
    wait_start();
    for (int g = 0; g < 5; g++) begin
      if (g == 4) req_valid = '0;
      repeat (2) tick();
      TxReady = 1'b1;
      tick();
      TxReady = 1'b0;
      n = 1;
      if (g < 4) begin
        for (int i = 0; i < 20 && !TxStart; i++) begin tick(); n++; end
        chk("fair_gap", 32'(n), 32'd3);
      end
    end
    hold = 1'b0;
    repeat (3) tick();
    chk_log("fair", 0, 1, 2, 3, 0, 5);

    // Wrap from LastId=3 with requesters 0 and 3.
    do_reset();
    req_valid = 4'b1001;
    wait_start();
    tick();
    pulse_ready();
    wait_start();
    chk("wrap_data", 32'(TxData), 32'h44);
    pulse_ready();
    repeat (3) tick();
    chk_log("wrap", 0, 3, 0, 0, 0, 2);

    // Watchdog expiry, then the next requester is served.
    glog.delete();
    req_valid = 4'b0011;
    wait_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); n++;
      if (Timeout) break;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_busy",   32'(Busy), 32'd0);
    wait_start();
    chk("tmo_next_id", 32'(ActiveId), 32'd1);
    pulse_ready();
    repeat (2) tick();
    chk_log("tmo", 0, 1, 0, 0, 0, 2);

    // Ready on the expiry cycle wins over the watchdog.
    req_valid = 4'b0100;
    wait_start();
    repeat (15) tick();
    TxReady = 1'b1;
    tick();
    TxReady = 1'b0;
    saw = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (Timeout) saw = 1; end
    chk("collide_no_tmo", 32'(saw), 32'd0);
    chk("collide_busy",   32'(Busy), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    req_valid = 4'b1000;
    wait_start();
    repeat (3) tick();
    ResetN = 1'b0;
    #1;
    chk("rst_busy",     32'(Busy), 32'd0);
    chk("rst_txdata",   32'(TxData), 32'd0);
    chk("rst_activeid", 32'(ActiveId), 32'd0);
    chk("rst_txstart",  32'(TxStart), 32'd0);
    chk("rst_timeout",  32'(Timeout), 32'd0);
    repeat (3) tick();
    ResetN = 1'b1;
    glog.delete();
    req_valid = 4'b0010;
    wait_grant();
    chk("rst_regrant", 32'(ReqGrant), 32'h2);
    tick();
    chk("rst_regrant_data", 32'(TxData), 32'h22);
    pulse_ready();
    repeat (3) tick();
    chk_log("rst", 1, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
